irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, meaning the number of interrupt sources (legal range 1..31).
REQ-002 The block SHALL have parameter PRIO_W, default 3, meaning the per-source priority width in bits (legal range 1..8).
REQ-003 The block SHALL have parameter EDGE_MASK, default 0, NUM_SRC bits wide; bit k=1 makes source k rising-edge triggered, 0 makes it level triggered.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 src_i  input  NUM_SRC  interrupt source lines, synchronous to clk.
REQ-007 cfg_we_i  input  1  configuration write strobe.
REQ-008 cfg_addr_i  input  8  configuration byte address, word aligned.
REQ-009 cfg_wdata_i  input  32  configuration write data.
REQ-010 cfg_rdata_o  output  32  configuration read data, combinational from cfg_addr_i.
REQ-011 irq_o  output  1  interrupt request to core.
REQ-012 irq_id_o  output  5  ID of requested interrupt (source index+1; 0 = none).
REQ-013 claim_i  input  1  one-cycle core claim pulse.
REQ-014 complete_i  input  1  one-cycle core completion pulse.
REQ-015 busy_o  output  1  high while an interrupt is in service.

Function
REQ-016 Register map SHALL be: 0x00 enable mask (RW, low NUM_SRC bits); 0x04 threshold (RW, low PRIO_W bits); 0x08 pending (RO); 0x10+4k priority of source k (RW, low PRIO_W bits, k<NUM_SRC).
REQ-017 Reads of unmapped addresses or unimplemented bits SHALL return 0; writes to unmapped addresses or to 0x08 SHALL have no effect.
REQ-018 src_i SHALL be registered once (src_q); edge detection SHALL compare src_q against its previous registered value.
REQ-019 Pending bit k SHALL set on the clock after a set condition on src_q: level high (level source) or 0->1 transition (edge source), in either case only while enable bit k is 1.
REQ-020 Pending bit k SHALL clear on a successful claim of ID k+1; if a set condition and the claim clear coincide, set SHALL win.
REQ-021 Clearing enable bit k SHALL clear pending bit k on the same edge.
REQ-022 Candidate SHALL be the pending source with the highest priority strictly greater than threshold; ties SHALL go to the lowest index; no candidate means ID 0.
REQ-023 The FSM SHALL have states IDLE, REQ and INSVC.
REQ-024 IDLE -> REQ when the candidate ID is nonzero; the candidate ID is latched into irq_id_o on that transition.
REQ-025 In REQ, irq_o SHALL be 1 and irq_id_o SHALL be held; a higher-priority candidate arriving SHALL replace the latched ID on the next edge (preemption before claim).
REQ-026 REQ -> INSVC on claim_i; the pending bit of the latched ID is cleared and irq_o drops on the same edge.
REQ-027 REQ -> IDLE, with irq_o=0 and irq_id_o=0, if the candidate becomes 0 before a claim.
REQ-028 INSVC SHALL drive busy_o=1 and irq_o=0, and SHALL retain irq_id_o; INSVC -> IDLE on complete_i, clearing irq_id_o; no nesting.
REQ-029 claim_i outside REQ and complete_i outside INSVC SHALL be ignored.
REQ-030 Latency: a source rising at edge n (sampled into src_q) SHALL set pending at edge n+1 and raise irq_o at edge n+2.

Reset
REQ-031 On rst=1 at a clock edge, all of the following SHALL be 0: FSM (IDLE), irq_o, irq_id_o, busy_o, pending, enable, threshold, all priorities, src_q and the edge-history register.
REQ-032 rst SHALL override every other input, including a claim or complete in the same cycle; reset mid-service SHALL return the FSM to IDLE with no residual pending.

Verification
REQ-033 Setup enable=0xFF, prio[2]=3, threshold=0; pulse src_i[2] high (level) -> irq_o=1, irq_id_o=3 two edges after sampling; claim -> busy_o=1; complete -> IDLE, and the request re-raises if src_i[2] is still high.
REQ-034 prio[1]=5, prio[4]=5, prio[6]=7; raise sources 1, 4 and 6 together -> ID 7; after complete -> ID 2 (tie to lowest index); after complete -> ID 5.
REQ-035 Edge source 3 (EDGE_MASK bit 3=1) held high for 10 cycles -> exactly one request; a new 0->1 edge coinciding with the claim edge -> pending stays 1.
REQ-036 prio[0]=2, threshold=2 -> no irq_o; set threshold=1 -> irq_o asserts with ID 1.
REQ-037 In REQ with ID 1, write enable=0 -> irq_o=0, ID=0 next edge; assert rst in INSVC together with complete_i -> all outputs 0 and cfg_rdata_o at 0x00 reads 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised interrupt controller with claim/complete handshake
module irq_ctrl #(
   parameter int                 NUM_SRC   = 8,
   parameter int                 PRIO_W    = 3,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               cfg_we_i,
   input  logic [7:0]         cfg_addr_i,
   input  logic [31:0]        cfg_wdata_i,
   output logic [31:0]        cfg_rdata_o,
   output logic               irq_o,
   output logic [4:0]         irq_id_o,
   input  logic               claim_i,
   input  logic               complete_i,
   output logic               busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, INSVC} state_t;

   state_t             state_q, state_d;
   logic [4:0]         id_q, id_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] src_q, src_prev_q;
   logic [NUM_SRC-1:0] set_vec, clr_vec;
   logic [PRIO_W-1:0]  threshold_q;
   logic [PRIO_W-1:0]  prio_q [NUM_SRC];
   logic [4:0]         cand_id;
   logic [PRIO_W-1:0]  cand_prio, lat_prio;
   logic               lat_elig;
   logic               claim_hit;
   logic               unused_wdata;

   // Upper write-data bits have no storage behind them.
   assign unused_wdata = ^cfg_wdata_i;

   assign irq_o    = (state_q == REQ);
   assign busy_o   = (state_q == INSVC);
   assign irq_id_o = id_q;

   // Pick the highest priority above threshold; strict compare keeps the lowest index on ties.
   always_comb begin
      cand_id   = '0;
      cand_prio = threshold_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (pending_q[k] && (prio_q[k] > cand_prio)) begin
            cand_prio = prio_q[k];
            cand_id   = 5'(k + 1);
         end
      end
   end

   // Look up the currently latched source so preemption can compare against it.
   always_comb begin
      lat_prio = '0;
      lat_elig = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (id_q == 5'(k + 1)) begin
            lat_prio = prio_q[k];
            lat_elig = pending_q[k] && (prio_q[k] > threshold_q);
         end
      end
   end

   // Request/service sequencing; a latched ID that lost eligibility is replaced by the new candidate.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      claim_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand_id != 5'd0) begin
               state_d = REQ;
               id_d    = cand_id;
            end
         end
         REQ: begin
            if (claim_i) begin
               state_d   = INSVC;
               claim_hit = 1'b1;
            end else if (cand_id == 5'd0) begin
               state_d = IDLE;
               id_d    = '0;
            end else if (!lat_elig || (cand_prio > lat_prio)) begin
               id_d = cand_id;
            end
         end
         INSVC: begin
            if (complete_i) begin
               state_d = IDLE;
               id_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            id_d    = '0;
         end
      endcase
   end

   // Pending update: claim clears, a set condition overrides it, and disabled sources are dropped.
   always_comb begin
      enable_d = enable_q;
      if (cfg_we_i && (cfg_addr_i == 8'h00)) begin
         enable_d = cfg_wdata_i[NUM_SRC-1:0];
      end
      set_vec = enable_q & src_q & ~(EDGE_MASK & src_prev_q);
      clr_vec = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (claim_hit && (id_q == 5'(k + 1))) begin
            clr_vec[k] = 1'b1;
         end
      end
      pending_d = ((pending_q & ~clr_vec) | set_vec) & enable_d;
   end

   // Control state and latched interrupt ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   // Source sampling, pending bits and configuration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q       <= '0;
         src_prev_q  <= '0;
         pending_q   <= '0;
         enable_q    <= '0;
         threshold_q <= '0;
         for (int k = 0; k < NUM_SRC; k++) begin
            prio_q[k] <= '0;
         end
      end else begin
         src_q      <= src_i;
         src_prev_q <= src_q;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         if (cfg_we_i && (cfg_addr_i == 8'h04)) begin
            threshold_q <= cfg_wdata_i[PRIO_W-1:0];
         end
         for (int k = 0; k < NUM_SRC; k++) begin
            if (cfg_we_i && (cfg_addr_i == 8'(16 + 4 * k))) begin
               prio_q[k] <= cfg_wdata_i[PRIO_W-1:0];
            end
         end
      end
   end

   // Register readback; anything not decoded reads as zero.
   always_comb begin
      cfg_rdata_o = '0;
      if (cfg_addr_i == 8'h00) begin
         cfg_rdata_o = 32'(enable_q);
      end else if (cfg_addr_i == 8'h04) begin
         cfg_rdata_o = 32'(threshold_q);
      end else if (cfg_addr_i == 8'h08) begin
         cfg_rdata_o = 32'(pending_q);
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         if (cfg_addr_i == 8'(16 + 4 * k)) begin
            cfg_rdata_o = 32'(prio_q[k]);
         end
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

   localparam int         N  = 8;
   localparam int         PW = 3;
   localparam logic [7:0] EM = 8'h08;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src = '0;
   logic        cfg_we = 1'b0;
   logic [7:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        irq;
   logic [4:0]  irq_id;
   logic        claim = 1'b0;
   logic        complete = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_ctrl #(.NUM_SRC(N), .PRIO_W(PW), .EDGE_MASK(EM)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_i       (src),
      .cfg_we_i    (cfg_we),
      .cfg_addr_i  (cfg_addr),
      .cfg_wdata_i (cfg_wdata),
      .cfg_rdata_o (cfg_rdata),
      .irq_o       (irq),
      .irq_id_o    (irq_id),
      .claim_i     (claim),
      .complete_i  (complete),
      .busy_o      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   bit       m_en   [N];
   int       m_thr;
   int       m_prio [N];
   bit       m_pend [N];
   bit       m_srcq [N];
   bit       m_prev [N];
   bit       m_irq;
   bit       m_busy;
   int       m_id;
   bit       m_valid = 1'b0;
   logic [7:0] em_v = EM;

   function automatic bit m_elig(int k);
      return m_pend[k] && (m_prio[k] > m_thr);
   endfunction

   function automatic int m_cand();
      int maxp = -1;
      for (int k = 0; k < N; k++)
         if (m_elig(k) && m_prio[k] > maxp) maxp = m_prio[k];
      if (maxp < 0) return 0;
      for (int k = 0; k < N; k++)
         if (m_elig(k) && m_prio[k] == maxp) return k + 1;
      return 0;
   endfunction

   function automatic logic [31:0] mread(logic [7:0] a);
      logic [31:0] r = '0;
      int ai = int'(a);
      if (ai == 0) begin
         for (int k = 0; k < N; k++) r[k] = m_en[k];
      end else if (ai == 4) begin
         r = 32'(m_thr);
      end else if (ai == 8) begin
         for (int k = 0; k < N; k++) r[k] = m_pend[k];
      end else if (ai >= 16 && ai < 16 + 4 * N && (ai % 4) == 0) begin
         r = 32'(m_prio[(ai - 16) / 4]);
      end
      return r;
   endfunction

   always @(posedge clk) begin : model
      int cand;
      int clr;
      int ai;
      bit en_new [N];
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            m_en[k] = 0; m_prio[k] = 0; m_pend[k] = 0; m_srcq[k] = 0; m_prev[k] = 0;
         end
         m_thr = 0; m_irq = 0; m_busy = 0; m_id = 0;
      end else begin
         cand = m_cand();
         clr  = 0;
         if (m_busy) begin
            if (complete) begin m_busy = 0; m_id = 0; end
         end else if (m_irq) begin
            if (claim) begin
               m_irq = 0; m_busy = 1; clr = m_id;
            end else if (cand == 0) begin
               m_irq = 0; m_id = 0;
            end else if (!m_elig(m_id - 1) || m_prio[cand - 1] > m_prio[m_id - 1]) begin
               m_id = cand;
            end
         end else if (cand != 0) begin
            m_irq = 1; m_id = cand;
         end
         en_new = m_en;
         if (cfg_we && cfg_addr == 8'h00)
            for (int k = 0; k < N; k++) en_new[k] = cfg_wdata[k];
         for (int k = 0; k < N; k++) begin
            if (clr == k + 1) m_pend[k] = 0;
            if (m_en[k] && m_srcq[k] && !(em_v[k] && m_prev[k])) m_pend[k] = 1;
            if (!en_new[k]) m_pend[k] = 0;
         end
         ai = int'(cfg_addr);
         if (cfg_we) begin
            if (ai == 4) m_thr = int'(cfg_wdata[PW-1:0]);
            if (ai >= 16 && ai < 16 + 4 * N && (ai % 4) == 0)
               m_prio[(ai - 16) / 4] = int'(cfg_wdata[PW-1:0]);
         end
         m_en = en_new;
         m_prev = m_srcq;
         for (int k = 0; k < N; k++) m_srcq[k] = src[k];
      end
      m_valid = 1'b1;
   end

   // Every cycle, away from the active edge, the DUT must match the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp_irq",   32'(irq),    32'(m_irq));
         chk("cmp_id",    32'(irq_id), 32'(m_id));
         chk("cmp_busy",  32'(busy),   32'(m_busy));
         chk("cmp_rdata", cfg_rdata,   mread(cfg_addr));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(); rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic serve();
      claim = 1'b1; cyc(); claim = 1'b0;
      complete = 1'b1; cyc(); complete = 1'b0;
      cyc();
   endtask

   function automatic logic [7:0] pick_addr();
      case ($urandom % 6)
         0:       return 8'h00;
         1:       return 8'h04;
         2:       return 8'h08;
         3, 4:    return 8'(16 + 4 * ($urandom % 10));
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int nreq;
      logic prev_irq;

      rst = 1'b1; cyc(); cyc();
      chk("rst_irq", 32'(irq), 0);
      chk("rst_id", 32'(irq_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_enable", cfg_rdata, 0);
      rst = 1'b0;

      // Level source 2: latency, claim, complete, re-raise, set beats claim-clear
      cfg_write(8'h00, 32'hFF); cfg_write(8'h18, 3); cfg_addr = 8'h08;
      src = 8'h04; cyc(); src = 8'h00; cyc();
      chk("t33_pend", cfg_rdata, 32'h4);
      chk("t33_irq_early", 32'(irq), 0);
      cyc();
      chk("t33_irq", 32'(irq), 1);
      chk("t33_id", 32'(irq_id), 3);
      claim = 1'b1; cyc(); claim = 1'b0;
      chk("t33_busy", 32'(busy), 1);
      chk("t33_irq_claimed", 32'(irq), 0);
      chk("t33_pend_clr", cfg_rdata, 0);
      src = 8'h04; cyc(); cyc();
      complete = 1'b1; cyc(); complete = 1'b0;
      chk("t33_idle_busy", 32'(busy), 0);
      chk("t33_idle_id", 32'(irq_id), 0);
      cyc();
      chk("t33_reraise", 32'(irq), 1);
      chk("t33_reraise_id", 32'(irq_id), 3);
      claim = 1'b1; cyc(); claim = 1'b0;
      chk("t33_set_wins", cfg_rdata, 32'h4);
      src = 8'h00;
      complete = 1'b1; cyc(); complete = 1'b0;
      cyc(); serve();

      // Priority ordering and tie-break
      do_reset();
      cfg_write(8'h00, 32'hFF); cfg_write(8'h14, 5); cfg_write(8'h20, 5); cfg_write(8'h28, 7);
      src = 8'h52; cyc(); src = 8'h00; cyc(); cyc();
      chk("t34_irq", 32'(irq), 1);
      chk("t34_id7", 32'(irq_id), 7);
      serve(); chk("t34_id2", 32'(irq_id), 2);
      serve(); chk("t34_id5", 32'(irq_id), 5);
      serve(); chk("t34_done", 32'(irq), 0);

      // Edge source 3
      do_reset();
      cfg_write(8'h00, 32'hFF); cfg_write(8'h1C, 1); cfg_addr = 8'h08;
      src = 8'h08; nreq = 0; prev_irq = irq;
      repeat (10) begin
         cyc();
         if (irq && !prev_irq) nreq++;
         prev_irq = irq;
      end
      chk("t35_one_req", 32'(nreq), 1);
      claim = 1'b1; cyc(); claim = 1'b0;
      chk("t35_pend_clr", cfg_rdata, 0);
      complete = 1'b1; cyc(); complete = 1'b0;
      cyc(); cyc();
      chk("t35_no_rereq", 32'(irq), 0);
      src = 8'h00; cyc(); cyc();
      src = 8'h08; cyc(); src = 8'h00; cyc(); src = 8'h08; cyc();
      chk("t35_req_id", 32'(irq_id), 4);
      claim = 1'b1; cyc(); claim = 1'b0; src = 8'h00;
      chk("t35_pend_kept", cfg_rdata, 32'h8);
      chk("t35_busy", 32'(busy), 1);
      complete = 1'b1; cyc(); complete = 1'b0; cyc();
      chk("t35_rereq", 32'(irq), 1);
      chk("t35_rereq_id", 32'(irq_id), 4);

      // Threshold
      do_reset();
      cfg_write(8'h00, 32'hFF); cfg_write(8'h10, 2); cfg_write(8'h04, 2);
      src = 8'h01; repeat (4) cyc();
      chk("t36_below_thr", 32'(irq), 0);
      cfg_write(8'h04, 1); cyc();
      chk("t36_irq", 32'(irq), 1);
      chk("t36_id", 32'(irq_id), 1);

      // Disable while requesting, then reset during service with complete
      cfg_write(8'h00, 0); cfg_addr = 8'h08; #1;
      chk("t37_pend_clr", cfg_rdata, 0);
      cyc();
      chk("t37_irq_drop", 32'(irq), 0);
      chk("t37_id_drop", 32'(irq_id), 0);
      cfg_write(8'h00, 32'hFF); cyc(); cyc();
      chk("t37_req_again", 32'(irq), 1);
      claim = 1'b1; cyc(); claim = 1'b0;
      chk("t37_busy", 32'(busy), 1);
      rst = 1'b1; complete = 1'b1; cyc(); rst = 1'b0; complete = 1'b0; src = 8'h00;
      cfg_addr = 8'h00; #1;
      chk("t37_rst_busy", 32'(busy), 0);
      chk("t37_rst_irq", 32'(irq), 0);
      chk("t37_rst_id", 32'(irq_id), 0);
      chk("t37_rst_enable", cfg_rdata, 0);
      cfg_addr = 8'h08; #1;
      chk("t37_rst_pend", cfg_rdata, 0);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom % 300 == 0);
         src      = src ^ 8'($urandom & $urandom & $urandom);
         claim    = (m_irq && ($urandom % 3 == 0)) || ($urandom % 20 == 0);
         complete = (m_busy && ($urandom % 4 == 0)) || ($urandom % 20 == 0);
         cfg_we   = ($urandom % 4 == 0);
         cfg_addr = pick_addr();
         cfg_wdata = (cfg_addr == 8'h04) ? 32'($urandom % 3) : $urandom;
         cyc();
      end
      rst = 1'b0; cfg_we = 1'b0; claim = 1'b0; complete = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
